// File: rtl/ram_pkg.sv
// Shared constants and types for the simple dual-port RAM and its clear sequencer.
package ram_pkg;

    // Same-address read-during-write behaviour
    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    // Clear sequencer states
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

endpackage

// File: rtl/ram_clear_seq.sv
// Clear sequencer: walks the address space from 0 to SIZE-1 writing zero,
// holding busy high for exactly SIZE cycles. Started by a clear pulse or,
// optionally, automatically on the first edge after reset release.
module ram_clear_seq
    import ram_pkg::*;
#(
    parameter int SIZE           = 512,
    parameter int ABITS          = 9,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    output logic             busy,
    output logic [ABITS-1:0] clr_addr
);

    localparam logic [ABITS-1:0] LAST_ADDR = ABITS'(SIZE - 1);

    clr_state_t       r_state;
    logic [ABITS-1:0] r_cnt;
    logic             r_boot;
    logic             r_busy;

    // Clear FSM with registered busy; r_boot arms the post-reset auto clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_boot  <= (CLEAR_ON_RESET != 0);
            r_busy  <= 1'b0;
        end else begin
            r_boot <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (clear || r_boot) begin
                        r_state <= ST_CLEAR;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    // New clear requests are simply not looked at here
                    if (r_cnt == LAST_ADDR) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + ABITS'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign clr_addr = r_cnt;

endmodule

// File: rtl/ram_sdp.sv
// Simple dual-port RAM: one write port with per-lane enables, one read port
// with 1 or 2 cycles of latency, selectable read-during-write behaviour and a
// built-in zeroing sequence. The array itself is never reset.
module ram_sdp
    import ram_pkg::*;
#(
    parameter  int WIDTH          = 64,
    parameter  int SIZE           = 512,
    parameter  int BYTE_WIDTH     = 8,
    parameter  int RD_LATENCY     = 1,
    parameter  int RDW_MODE       = 0,
    parameter  int CLEAR_ON_RESET = 1,
    localparam int ABITS          = $clog2(SIZE),
    localparam int NBE            = WIDTH / BYTE_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rden,
    input  logic [ABITS-1:0] rdaddr,
    output logic [WIDTH-1:0] rddata,
    output logic             rdvalid,
    input  logic             wren,
    input  logic [ABITS-1:0] wraddr,
    input  logic [WIDTH-1:0] wrdata,
    input  logic [NBE-1:0]   wrbe,
    input  logic             clear,
    output logic             busy
);

    // Elaboration-time parameter sanity
    if ((WIDTH % BYTE_WIDTH) != 0 || WIDTH < BYTE_WIDTH) begin : g_bad_width
        $error("ram_sdp: WIDTH must be a non-zero multiple of BYTE_WIDTH");
    end
    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
        $error("ram_sdp: RD_LATENCY must be 1 or 2");
    end
    if (RDW_MODE != RDW_OLD && RDW_MODE != RDW_NEW) begin : g_bad_rdw
        $error("ram_sdp: RDW_MODE must be 0 or 1");
    end
    if (SIZE < 2) begin : g_bad_size
        $error("ram_sdp: SIZE must be at least 2");
    end

    localparam logic [ABITS:0] LP_SIZE = (ABITS + 1)'(SIZE);

    logic             w_busy;
    logic [ABITS-1:0] w_clr_addr;
    logic             w_rd_inrange;
    logic             w_wr_inrange;
    logic             w_rd_acc;
    logic             w_wr_acc;
    logic [NBE-1:0]   w_byp_be;
    logic [WIDTH-1:0] w_d1;

    ram_clear_seq #(
        .SIZE           (SIZE),
        .ABITS          (ABITS),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .busy     (w_busy),
        .clr_addr (w_clr_addr)
    );

    assign busy         = w_busy;
    assign w_rd_inrange = ({1'b0, rdaddr} < LP_SIZE);
    assign w_wr_inrange = ({1'b0, wraddr} < LP_SIZE);
    assign w_rd_acc     = rden && !w_busy;
    assign w_wr_acc     = wren && !w_busy && w_wr_inrange;

    // Lanes that must come from wrdata instead of the (pre-write) array word
    assign w_byp_be = (RDW_MODE == RDW_NEW && w_wr_acc && rdaddr == wraddr) ? wrbe : '0;

    logic [WIDTH-1:0] r_mem [SIZE];
    logic [WIDTH-1:0] r_mem_rd;

    // Storage and registered array read; the registered read naturally yields
    // the pre-write word on a same-address collision
    always_ff @(posedge clk) begin
        if (w_busy) begin
            r_mem[w_clr_addr] <= '0;
        end else if (w_wr_acc) begin
            for (int i = 0; i < NBE; i++) begin
                if (wrbe[i]) begin
                    r_mem[wraddr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wrdata[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
        if (w_rd_acc && w_rd_inrange) begin
            r_mem_rd <= r_mem[rdaddr];
        end
    end

    logic             r_v1;
    logic             r_zero1;
    logic [NBE-1:0]   r_byp_be1;
    logic [WIDTH-1:0] r_byp_d1;

    // First read stage side-band: valid, out-of-range/reset forcing, bypass lanes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1      <= 1'b0;
            r_zero1   <= 1'b1;
            r_byp_be1 <= '0;
            r_byp_d1  <= '0;
        end else begin
            r_v1 <= w_rd_acc;
            if (w_rd_acc) begin
                r_zero1   <= !w_rd_inrange;
                r_byp_be1 <= w_byp_be;
                r_byp_d1  <= wrdata;
            end
        end
    end

    // Per-lane merge of array word and bypassed write data
    for (genvar gi = 0; gi < NBE; gi++) begin : g_lane
        assign w_d1[gi*BYTE_WIDTH +: BYTE_WIDTH] =
            r_zero1        ? '0 :
            r_byp_be1[gi]  ? r_byp_d1[gi*BYTE_WIDTH +: BYTE_WIDTH] :
                             r_mem_rd[gi*BYTE_WIDTH +: BYTE_WIDTH];
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic             r_v2;
        logic [WIDTH-1:0] r_d2;

        // Optional output register stage for timing
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v2 <= 1'b0;
                r_d2 <= '0;
            end else begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_d2 <= w_d1;
                end
            end
        end

        assign rdvalid = r_v2;
        assign rddata  = r_d2;
    end else begin : g_lat1
        assign rdvalid = r_v1;
        assign rddata  = w_d1;
    end

endmodule

// File: tb/tb_ram_sdp.sv
// Randomized bench for ram_sdp: two instances (512 deep / latency 1 / old-data,
// 300 deep / latency 2 / new-data) share one stimulus stream and are checked
// every cycle against an abstract reference memory with a timed result queue.
module tb_ram_sdp;

    logic        clk;
    logic        rst_n;
    logic        rden;
    logic [8:0]  rdaddr;
    logic        wren;
    logic [8:0]  wraddr;
    logic [63:0] wrdata;
    logic [7:0]  wrbe;
    logic        clear;

    logic [63:0] rddata_o [2];
    logic        rdvalid_o [2];
    logic        busy_o [2];

    ram_sdp #(
        .WIDTH(64), .SIZE(512), .BYTE_WIDTH(8),
        .RD_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(1)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .rden(rden), .rdaddr(rdaddr), .rddata(rddata_o[0]), .rdvalid(rdvalid_o[0]),
        .wren(wren), .wraddr(wraddr), .wrdata(wrdata), .wrbe(wrbe),
        .clear(clear), .busy(busy_o[0])
    );

    ram_sdp #(
        .WIDTH(64), .SIZE(300), .BYTE_WIDTH(8),
        .RD_LATENCY(2), .RDW_MODE(1), .CLEAR_ON_RESET(1)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .rden(rden), .rdaddr(rdaddr), .rddata(rddata_o[1]), .rdvalid(rdvalid_o[1]),
        .wren(wren), .wraddr(wraddr), .wrdata(wrdata), .wrbe(wrbe),
        .clear(clear), .busy(busy_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        logic [63:0] d;
    } rd_t;

    int          sz  [2] = '{512, 300};
    int          lat [2] = '{1, 2};
    int          rdw [2] = '{0, 1};
    logic [63:0] mem_m [2][512];
    bit          busy_m [2];
    int          clr_left [2];
    bit          boot [2];
    logic [63:0] hold [2];
    rd_t         q0 [$];
    rd_t         q1 [$];
    int          cyc;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d, input logic [7:0] be);
        logic [63:0] r;
        r = old;
        for (int i = 0; i < 8; i++) if (be[i]) r[i*8 +: 8] = d[i*8 +: 8];
        return r;
    endfunction

    // Effect of the coming clock edge on instance k, given the current inputs
    task automatic model_edge(input int k);
        logic [63:0] rd;
        bit          rd_acc, wr_acc;
        rd_t         e;
        rd_acc = !busy_m[k] && rden;
        wr_acc = !busy_m[k] && wren && (int'(wraddr) < sz[k]);
        if (rd_acc) begin
            if (int'(rdaddr) >= sz[k]) rd = 64'h0;
            else begin
                rd = mem_m[k][rdaddr];
                if (rdw[k] == 1 && wr_acc && wraddr == rdaddr) rd = merge(rd, wrdata, wrbe);
            end
            e.due = cyc + lat[k] - 1;
            e.d   = rd;
            if (k == 0) q0.push_back(e); else q1.push_back(e);
        end
        if (wr_acc) mem_m[k][wraddr] = merge(mem_m[k][wraddr], wrdata, wrbe);
        if (busy_m[k]) begin
            mem_m[k][sz[k] - clr_left[k]] = 64'h0;
            clr_left[k]--;
            if (clr_left[k] == 0) busy_m[k] = 1'b0;
        end else if (clear || boot[k]) begin
            busy_m[k]   = 1'b1;
            clr_left[k] = sz[k];
        end
        boot[k] = 1'b0;
    endtask

    task automatic check_outputs(input int k);
        bit exp_v;
        exp_v = 1'b0;
        if (k == 0 && q0.size() > 0 && q0[0].due == cyc) begin
            exp_v = 1'b1; hold[k] = q0[0].d; void'(q0.pop_front());
        end
        if (k == 1 && q1.size() > 0 && q1[0].due == cyc) begin
            exp_v = 1'b1; hold[k] = q1[0].d; void'(q1.pop_front());
        end
        check_val($sformatf("u%0d rdvalid", k), {63'h0, rdvalid_o[k]}, {63'h0, exp_v});
        check_val($sformatf("u%0d rddata", k), rddata_o[k], hold[k]);
        check_val($sformatf("u%0d busy", k), {63'h0, busy_o[k]}, {63'h0, busy_m[k]});
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic set_idle();
        rden = 1'b0; rdaddr = '0; wren = 1'b0; wraddr = '0;
        wrdata = '0; wrbe = '0; clear = 1'b0;
    endtask

    task automatic step();
        for (int k = 0; k < 2; k++) model_edge(k);
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) check_outputs(k);
        cyc++;
    endtask

    task automatic idle(input int n);
        set_idle();
        repeat (n) step();
    endtask

    task automatic do_read(input logic [8:0] a);
        set_idle(); rden = 1'b1; rdaddr = a; step();
    endtask

    task automatic do_write(input logic [8:0] a, input logic [63:0] d, input logic [7:0] be);
        set_idle(); wren = 1'b1; wraddr = a; wrdata = d; wrbe = be; step();
    endtask

    // Asynchronous reset asserted mid-cycle, checked before any clock edge
    task automatic do_reset(input int ncyc);
        @(negedge clk);
        set_idle();
        rst_n = 1'b0;
        #1;
        q0.delete(); q1.delete();
        for (int k = 0; k < 2; k++) begin
            hold[k] = 64'h0; busy_m[k] = 1'b0; clr_left[k] = 0; boot[k] = 1'b1;
            check_val($sformatf("u%0d rst rdvalid", k), {63'h0, rdvalid_o[k]}, 64'h0);
            check_val($sformatf("u%0d rst rddata", k), rddata_o[k], 64'h0);
            check_val($sformatf("u%0d rst busy", k), {63'h0, busy_o[k]}, 64'h0);
        end
        repeat (ncyc) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        cyc   = 0;
        rst_n = 1'b1;
        set_idle();
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < 512; a++) mem_m[k][a] = 64'h0;

        // Power-up reset, then automatic clear (512 / 300 busy cycles)
        do_reset(2);
        idle(520);

        // Post-clear reads
        do_read(9'd0);
        do_read(9'd255);
        do_read(9'd511);
        idle(3);

        // Byte-lane merge on address 5
        do_write(9'd5, 64'h1122334455667788, 8'hFF);
        do_write(9'd5, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
        do_read(9'd5);
        idle(3);

        // Same-address read during write on address 9
        set_idle();
        wren = 1'b1; wraddr = 9'd9; wrdata = 64'h000000000000FFFF; wrbe = 8'hFF;
        rden = 1'b1; rdaddr = 9'd9;
        step();
        do_read(9'd9);
        idle(3);

        // Back-to-back reads of 0..3
        for (int a = 0; a < 4; a++) do_write(9'(a), 64'hC0DE_0000_0000_0000 | 64'(a * 17 + 1), 8'hFF);
        for (int a = 0; a < 4; a++) begin
            set_idle(); rden = 1'b1; rdaddr = 9'(a); step();
        end
        idle(3);

        // Beyond-depth access (only out of range for the 300-deep instance)
        do_write(9'd310, 64'hDEADBEEFCAFEF00D, 8'hFF);
        do_read(9'd310);
        idle(3);

        // Randomized traffic with occasional clear requests
        for (int n = 0; n < 700; n++) begin
            set_idle();
            rden   = 1'($urandom_range(0, 1));
            wren   = 1'($urandom_range(0, 1));
            rdaddr = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 7)) : 9'($urandom_range(0, 319));
            wraddr = ($urandom_range(0, 3) == 0) ? rdaddr : 9'($urandom_range(0, 319));
            wrdata = {$urandom, $urandom};
            wrbe   = 8'($urandom);
            clear  = ($urandom_range(0, 399) == 0);
            step();
        end
        idle(520);

        // Sweep to compare whole contents
        for (int a = 0; a < 320; a++) do_read(9'(a));
        idle(3);

        // Clear, ignored second clear, reset mid-clear, full restart
        set_idle(); clear = 1'b1; step();
        idle(9);
        set_idle(); clear = 1'b1; step();
        idle(89);
        do_reset(3);
        idle(520);
        do_read(9'd0);
        do_read(9'd200);
        do_read(9'd299);
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
